// File: rtl/dot_product_loader.sv
// dot_product_loader: valid/ready beat loader that fills the dotProduct SRAMs, kicks compute and reports done (optional WAIT watchdog: LOADER_TIMEOUT_EN)
module dot_product_loader #(
  parameter int Addr_Width     = 4,
  parameter int Ram_Depth      = 1 << Addr_Width,
  parameter int Nums_SRAM_In   = 2,
  parameter int Nums_SRAM_Out  = 1,
  parameter int Para_Deg       = 1,
  parameter int Data_Width_In  = 8,
  parameter int Data_Width_Out = 16,
  parameter int Timeout_Cycles = 64
) (
  input  logic                                          clk,
  input  logic                                          Loader_reset_n,
  input  logic                                          start,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [Nums_SRAM_In*Para_Deg*Data_Width_In-1:0]   in_data,
  input  logic [Nums_SRAM_Out*Para_Deg*Data_Width_Out-1:0] in_old,
  output logic                                          mem_wr_en,
  output logic [Addr_Width-1:0]                         mem_wr_addr,
  output logic [Nums_SRAM_In*Para_Deg*Data_Width_In-1:0]   mem_wr_data_in,
  output logic [Nums_SRAM_Out*Para_Deg*Data_Width_Out-1:0] mem_wr_data_out,
  output logic                                          compute_start,
  input  logic                                          compute_done,
  output logic                                          busy,
  output logic                                          done,
  output logic                                          timeout_err,
  output logic [Addr_Width:0]                           load_count
);
  localparam int Num_Beats = Ram_Depth / Para_Deg;
  typedef enum logic [2:0] {IDLE, LOAD, FLUSH, KICK, WAIT, DONE} state_t;
  state_t state;
  logic accept;
  assign in_ready = state == LOAD;
  assign busy = state != IDLE;
  assign compute_start = state == KICK;
  assign done = state == DONE;
  assign accept = in_valid && in_ready;
`ifdef LOADER_TIMEOUT_EN
  localparam int TW = $clog2(Timeout_Cycles + 1);
  logic [TW-1:0] wait_cnt;
`else
  assign timeout_err = 1'b0;
`endif
  // Session sequencer; the beat counter doubles as the write address and saturates by leaving LOAD
  always_ff @(posedge clk) begin
    if (!Loader_reset_n) begin
      state <= IDLE;
      mem_wr_en <= 1'b0;
      mem_wr_addr <= '0;
      mem_wr_data_in <= '0;
      mem_wr_data_out <= '0;
      load_count <= '0;
`ifdef LOADER_TIMEOUT_EN
      timeout_err <= 1'b0;
      wait_cnt <= '0;
`endif
    end else begin
      mem_wr_en <= accept;
      if (accept) begin
        mem_wr_addr <= load_count[Addr_Width-1:0];
        mem_wr_data_in <= in_data;
        mem_wr_data_out <= in_old;
        load_count <= load_count + 1'b1;
      end
      case (state)
        IDLE: if (start) begin
          state <= LOAD;
          load_count <= '0;
`ifdef LOADER_TIMEOUT_EN
          timeout_err <= 1'b0;
`endif
        end
        LOAD: if (accept && load_count == (Addr_Width+1)'(Num_Beats - 1)) state <= FLUSH;
        FLUSH: state <= KICK;
        KICK: begin
          state <= WAIT;
`ifdef LOADER_TIMEOUT_EN
          wait_cnt <= '0;
`endif
        end
        WAIT: if (compute_done) state <= DONE;
`ifdef LOADER_TIMEOUT_EN
        else if (wait_cnt == TW'(Timeout_Cycles - 1)) begin
          state <= DONE;
          timeout_err <= 1'b1;
        end else wait_cnt <= wait_cnt + 1'b1;
`endif
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/dot_product_loader.md
Name: dot_product_loader

Overview:
Upstream load sequencer for the dotProduct array. It accepts packed input-vector beats and old-output beats over a valid/ready stream. Each beat is written to consecutive SRAM addresses with a registered write port. When the last beat has landed it pulses the compute start, then waits for the array's completion and reports done. It replaces the hand-sequenced load_from_file/Computing stimulus with a self-timed controller.

Parameters:
Addr_Width, 4, SRAM address width
Ram_Depth, 16, SRAM entries per bank (1 << Addr_Width)
Nums_SRAM_In, 2, number of input-vector banks
Nums_SRAM_Out, 1, number of old-output banks
Para_Deg, 1, elements per address per bank; Ram_Depth must be divisible by Para_Deg
Data_Width_In, 8, input element width
Data_Width_Out, 16, output element width
Timeout_Cycles, 64, watchdog limit in WAIT (used only with the optional feature)

Ports:
clk  in  1  single clock, all logic on rising edge
Loader_reset_n  in  1  synchronous, active-low reset
start  in  1  begin a load session; sampled only in IDLE
in_valid  in  1  source beat valid
in_ready  out  1  loader accepts a beat
in_data  in  Nums_SRAM_In*Para_Deg*Data_Width_In  packed input-bank beat, bank b at [b*Para_Deg*Data_Width_In +: Para_Deg*Data_Width_In]
in_old  in  Nums_SRAM_Out*Para_Deg*Data_Width_Out  packed old-output beat, same packing
mem_wr_en  out  1  SRAM write strobe, all banks
mem_wr_addr  out  Addr_Width  SRAM write address
mem_wr_data_in  out  Nums_SRAM_In*Para_Deg*Data_Width_In  registered copy of in_data
mem_wr_data_out  out  Nums_SRAM_Out*Para_Deg*Data_Width_Out  registered copy of in_old
compute_start  out  1  one-cycle pulse; drives Computing
compute_done  in  1  array completion
busy  out  1  high in every state except IDLE
done  out  1  one-cycle session-complete pulse
timeout_err  out  1  sticky watchdog flag (constant 0 without the macro)
load_count  out  Addr_Width+1  beats accepted this session

Behaviour:
- Num_Beats = Ram_Depth/Para_Deg. A beat is accepted when in_valid && in_ready on a rising edge.
- Reset (Loader_reset_n=0 at an edge): state=IDLE. All outputs are 0 and load_count=0, valid from the cycle after that edge. Reset mid-session aborts the session without a done pulse.
- FSM state IDLE: in_ready=0. If start=1, go to LOAD and clear load_count and the address counter.
- FSM state LOAD: in_ready=1 (Moore decode). On each accept, next cycle: mem_wr_en=1, mem_wr_addr=beat index, data registered. Write latency is 1 cycle and addresses increment by 1 per accept. With no accept, the next cycle has mem_wr_en=0 and no address advance. The accept of beat Num_Beats-1 moves the FSM to FLUSH.
- FSM state FLUSH: in_ready=0. The last write is visible on the write port. Go to KICK.
- FSM state KICK: compute_start=1 for exactly this cycle, mem_wr_en=0. Go to WAIT.
- FSM state WAIT: hold until compute_done=1, then go to DONE. compute_done outside WAIT is ignored.
- FSM state DONE: done=1 for one cycle, then go to IDLE. A start in the DONE cycle is ignored. A start in the following IDLE cycle is honoured.
- start while busy is ignored. in_valid outside LOAD is not accepted and produces no write.
- load_count saturates at Num_Beats and holds through DONE. It clears only on a new start or on reset.
- mem_wr_addr wraps naturally at Ram_Depth. This is unreachable because Num_Beats <= Ram_Depth.

Optional Feature:
LOADER_TIMEOUT_EN
- Defined: a counter runs in WAIT. If compute_done is not seen within Timeout_Cycles cycles, go to DONE, pulse done, and set timeout_err. timeout_err clears on the next start or on reset.
- Undefined: no counter, WAIT holds indefinitely, and timeout_err is tied to 0.

Test Plan:
- Reset: hold Loader_reset_n=0 for 2 cycles with start=1 and in_valid=1. All outputs are 0, and no write occurs after reset release until start.
- Full load, back-to-back: start, then 16 beats with in_data={2i,i} and in_old=100+i. There are 16 writes with addr 0..15 and matching data, each 1 cycle after its accept. compute_start is high exactly once, 2 cycles after the last accept. load_count=16.
- Gapped source: in_valid high on alternate cycles. There are exactly 16 writes with contiguous addresses 0..15, and mem_wr_en=0 in gap cycles.
- Illegal events: in_valid=1 in IDLE gives no write and in_ready=0. A start pulse during LOAD and during WAIT leaves the session unaffected, with a single compute_start.
- Completion and reuse: compute_done is asserted 19 cycles after compute_start. done pulses for 1 cycle on the next edge, then IDLE. A second session writes from addr 0 again.
- Mid-load reset: assert reset after beat 7. Outputs are 0 the next cycle and compute_start never pulses. A new session starts at addr 0. With LOADER_TIMEOUT_EN and no compute_done, done and timeout_err assert 64 cycles after entering WAIT.
